// File: rtl/rcpu_io_pkg.sv
// Shared constants for the rcpu IO bridge: register map, status bit layout,
// TX serializer state encodings.
package rcpu_io_pkg;

  localparam int unsigned IO_W = 16;

  localparam logic [15:0] ADDR_UART_DATA   = 16'h0000;
  localparam logic [15:0] ADDR_UART_STATUS = 16'h0004;
  localparam logic [15:0] ADDR_LED         = 16'h0008;
  localparam logic [15:0] ADDR_TIMER       = 16'h000C;
  localparam logic [15:0] ADDR_RX          = 16'h0010;

  localparam int unsigned ST_RX_VALID = 0;
  localparam int unsigned ST_EMPTY    = 1;
  localparam int unsigned ST_FULL     = 2;
  localparam int unsigned ST_BUSY     = 3;
  localparam int unsigned ST_OVERFLOW = 4;

  localparam logic [1:0] TX_IDLE  = 2'd0;
  localparam logic [1:0] TX_START = 2'd1;
  localparam logic [1:0] TX_DATA  = 2'd2;
  localparam logic [1:0] TX_STOP  = 2'd3;

endpackage

// File: rtl/rcpu_io_bridge_if.sv
// CPU IO port bundle; bit 0 is the MSB to match the CPU-side declarations.
interface rcpu_io_bridge_if;
  import rcpu_io_pkg::*;

  logic            io_read_enable;
  logic            io_write_enable;
  logic [0:IO_W-1] io_address;
  logic [0:IO_W-1] io_write_data;
  logic [0:IO_W-1] io_read_data;

  modport master (output io_read_enable, io_write_enable, io_address, io_write_data,
                  input  io_read_data);
  modport slave  (input  io_read_enable, io_write_enable, io_address, io_write_data,
                  output io_read_data);
endinterface

// File: rtl/rcpu_uart_tx.sv
// UART transmitter: TX FIFO feeding an 8N1 serializer.
module rcpu_uart_tx
  import rcpu_io_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 104,
  parameter int unsigned FIFO_DEPTH   = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       i_push,
  input  logic [7:0] i_push_data,
  output logic       o_full_c,
  output logic       o_empty_c,
  output logic       o_busy_c,
  output logic       o_drop_c,
  output logic       o_uart_tx
);
  localparam int unsigned PW   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNTW = PW + 1;
  localparam int unsigned CW   = 16;

  logic [7:0]      r_mem [FIFO_DEPTH];
  logic [PW-1:0]   r_wr_ptr, r_rd_ptr;
  logic [CNTW-1:0] r_count;
  logic [1:0]      r_state, w_state_n;
  logic [CW-1:0]   r_cnt, w_cnt_n;
  logic [2:0]      r_bit, w_bit_n;
  logic [7:0]      r_shift, w_shift_n;
  logic            w_pop, w_push_ok, w_tx_n, w_bit_end;

  assign o_empty_c = (r_count == '0);
  assign o_full_c  = (r_count == CNTW'(FIFO_DEPTH));
  assign o_busy_c  = (r_state != TX_IDLE);
  // A pop in the same cycle frees the slot a full-FIFO push needs
  assign w_push_ok = i_push && (!o_full_c || w_pop);
  assign o_drop_c  = i_push && !w_push_ok;
  assign w_bit_end = (r_cnt == CW'(CLKS_PER_BIT - 1));

  // FIFO pointers and occupancy; pointers wrap with the power-of-two depth
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_pop)     r_rd_ptr <= r_rd_ptr + PW'(1);
      r_count <= r_count + CNTW'(w_push_ok) - CNTW'(w_pop);
    end
  end

  // FIFO storage, no reset needed
  always_ff @(posedge clk) begin
    if (w_push_ok) r_mem[r_wr_ptr] <= i_push_data;
  end

  // Serializer state, bit timing and registered line output
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= TX_IDLE;
      r_cnt     <= '0;
      r_bit     <= '0;
      r_shift   <= '0;
      o_uart_tx <= 1'b1;
    end else begin
      r_state   <= w_state_n;
      r_cnt     <= w_cnt_n;
      r_bit     <= w_bit_n;
      r_shift   <= w_shift_n;
      o_uart_tx <= w_tx_n;
    end
  end

  // Next-state logic; STOP chains straight into START when more data waits
  always_comb begin
    w_state_n = r_state;
    w_cnt_n   = r_cnt;
    w_bit_n   = r_bit;
    w_shift_n = r_shift;
    w_pop     = 1'b0;
    w_tx_n    = 1'b1;
    case (r_state)
      TX_IDLE: begin
        if (!o_empty_c) begin
          w_pop     = 1'b1;
          w_shift_n = r_mem[r_rd_ptr];
          w_cnt_n   = '0;
          w_state_n = TX_START;
        end
      end
      TX_START: begin
        if (w_bit_end) begin
          w_cnt_n   = '0;
          w_bit_n   = '0;
          w_state_n = TX_DATA;
        end else w_cnt_n = r_cnt + CW'(1);
      end
      TX_DATA: begin
        if (w_bit_end) begin
          w_cnt_n   = '0;
          w_shift_n = {1'b0, r_shift[7:1]};
          if (r_bit == 3'd7) w_state_n = TX_STOP;
          else               w_bit_n   = r_bit + 3'd1;
        end else w_cnt_n = r_cnt + CW'(1);
      end
      TX_STOP: begin
        if (w_bit_end) begin
          w_cnt_n = '0;
          if (!o_empty_c) begin
            w_pop     = 1'b1;
            w_shift_n = r_mem[r_rd_ptr];
            w_state_n = TX_START;
          end else w_state_n = TX_IDLE;
        end else w_cnt_n = r_cnt + CW'(1);
      end
      default: w_state_n = TX_IDLE;
    endcase
    case (w_state_n)
      TX_START: w_tx_n = 1'b0;
      TX_DATA:  w_tx_n = w_shift_n[0];
      default:  w_tx_n = 1'b1;
    endcase
  end

endmodule

// File: rtl/rcpu_io_bridge.sv
// Peripheral bridge behind the CPU IO port: UART TX, LED register, prescaled
// timer, registered read mux. Optional UART receiver under RCPU_IO_RX_EN.
module rcpu_io_bridge
  import rcpu_io_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT   = 104,
  parameter int unsigned FIFO_DEPTH     = 8,
  parameter int unsigned TIMER_PRESCALE = 1000
) (
  input  logic             clk,
  input  logic             reset,
  rcpu_io_bridge_if.slave  bus,
  output logic             uart_tx,
  input  logic             uart_rx,
  output logic [7:0]       leds
);
  logic [15:0] w_addr, w_wdata, w_rdata_n, w_status;
  logic [15:0] r_rdata, r_timer, r_presc;
  logic [7:0]  r_leds;
  logic        r_overflow;
  logic        w_rd, w_wr, w_push, w_full, w_empty, w_busy, w_drop, w_tick;
  logic        w_rx_valid, w_rx_ovf;

  assign w_rd    = bus.io_read_enable;
  assign w_wr    = bus.io_write_enable;
  assign w_addr  = bus.io_address;
  assign w_wdata = bus.io_write_data;
  assign bus.io_read_data = r_rdata;
  assign leds    = r_leds;
  assign w_push  = w_wr && (w_addr == ADDR_UART_DATA);
  assign w_tick  = (r_presc == 16'(TIMER_PRESCALE - 1));

  rcpu_uart_tx #(.CLKS_PER_BIT(CLKS_PER_BIT), .FIFO_DEPTH(FIFO_DEPTH)) u_tx (
    .clk(clk), .reset(reset), .i_push(w_push), .i_push_data(w_wdata[7:0]),
    .o_full_c(w_full), .o_empty_c(w_empty), .o_busy_c(w_busy),
    .o_drop_c(w_drop), .o_uart_tx(uart_tx)
  );

`ifdef RCPU_IO_RX_EN
  localparam logic [1:0] RX_IDLE  = 2'd0;
  localparam logic [1:0] RX_START = 2'd1;
  localparam logic [1:0] RX_DATA  = 2'd2;
  localparam logic [1:0] RX_STOP  = 2'd3;
  localparam int unsigned HALF    = CLKS_PER_BIT / 2;

  logic [1:0]  r_sync, r_rx_state, w_rx_state_n;
  logic [15:0] r_rx_cnt, w_rx_cnt_n;
  logic [2:0]  r_rx_bit, w_rx_bit_n;
  logic [7:0]  r_rx_shift, w_rx_shift_n, r_rx_data;
  logic        r_rx_prev, r_rx_valid, w_rx_line, w_rx_done, w_rd_rx, w_rx_end;

  assign w_rx_line  = r_sync[1];
  assign w_rd_rx    = w_rd && (w_addr == ADDR_RX);
  assign w_rx_end   = (r_rx_cnt == 16'(CLKS_PER_BIT - 1));
  assign w_rx_valid = r_rx_valid;
  // An unread byte being replaced counts as an overflow
  assign w_rx_ovf   = w_rx_done && r_rx_valid && !w_rd_rx;

  // Synchronizer, receiver state and holding register
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync     <= 2'b11;
      r_rx_prev  <= 1'b1;
      r_rx_state <= RX_IDLE;
      r_rx_cnt   <= '0;
      r_rx_bit   <= '0;
      r_rx_shift <= '0;
      r_rx_data  <= '0;
      r_rx_valid <= 1'b0;
    end else begin
      r_sync     <= {r_sync[0], uart_rx};
      r_rx_prev  <= w_rx_line;
      r_rx_state <= w_rx_state_n;
      r_rx_cnt   <= w_rx_cnt_n;
      r_rx_bit   <= w_rx_bit_n;
      r_rx_shift <= w_rx_shift_n;
      if (w_rx_done) begin
        r_rx_data  <= r_rx_shift;
        r_rx_valid <= 1'b1;
      end else if (w_rd_rx) r_rx_valid <= 1'b0;
    end
  end

  // Receiver next-state: confirm start at mid-bit, then sample every bit period
  always_comb begin
    w_rx_state_n = r_rx_state;
    w_rx_cnt_n   = r_rx_cnt + 16'd1;
    w_rx_bit_n   = r_rx_bit;
    w_rx_shift_n = r_rx_shift;
    w_rx_done    = 1'b0;
    case (r_rx_state)
      RX_IDLE: begin
        w_rx_cnt_n = '0;
        if (r_rx_prev && !w_rx_line) w_rx_state_n = RX_START;
      end
      RX_START: begin
        if (r_rx_cnt == 16'(HALF - 1)) begin
          w_rx_cnt_n   = '0;
          w_rx_bit_n   = '0;
          w_rx_state_n = w_rx_line ? RX_IDLE : RX_DATA;
        end
      end
      RX_DATA: begin
        if (w_rx_end) begin
          w_rx_cnt_n   = '0;
          w_rx_shift_n = {w_rx_line, r_rx_shift[7:1]};
          if (r_rx_bit == 3'd7) w_rx_state_n = RX_STOP;
          else                  w_rx_bit_n   = r_rx_bit + 3'd1;
        end
      end
      RX_STOP: begin
        if (w_rx_end) begin
          w_rx_cnt_n   = '0;
          w_rx_done    = w_rx_line;
          w_rx_state_n = RX_IDLE;
        end
      end
      default: w_rx_state_n = RX_IDLE;
    endcase
  end
`else
  logic w_unused;
  assign w_rx_valid = 1'b0;
  assign w_rx_ovf   = 1'b0;
  // Sink for the receive-only inputs
  assign w_unused   = uart_rx ^ (w_addr == ADDR_RX);
`endif

  // Sticky overflow; a new overflow event beats a same-cycle clear
  always_ff @(posedge clk) begin
    if (reset) r_overflow <= 1'b0;
    else if (w_drop || w_rx_ovf) r_overflow <= 1'b1;
    else if (w_wr && (w_addr == ADDR_UART_STATUS) && w_wdata[ST_OVERFLOW]) r_overflow <= 1'b0;
  end

  // LED register and prescaled timer; a timer write overrides a same-edge tick
  always_ff @(posedge clk) begin
    if (reset) begin
      r_leds  <= '0;
      r_timer <= '0;
      r_presc <= '0;
    end else begin
      if (w_wr && (w_addr == ADDR_LED)) r_leds <= w_wdata[7:0];
      if (w_wr && (w_addr == ADDR_TIMER)) begin
        r_timer <= w_wdata;
        r_presc <= '0;
      end else if (w_tick) begin
        r_timer <= r_timer + 16'd1;
        r_presc <= '0;
      end else r_presc <= r_presc + 16'd1;
    end
  end

  // Status word assembly
  always_comb begin
    w_status              = '0;
    w_status[ST_RX_VALID] = w_rx_valid;
    w_status[ST_EMPTY]    = w_empty;
    w_status[ST_FULL]     = w_full;
    w_status[ST_BUSY]     = w_busy;
    w_status[ST_OVERFLOW] = r_overflow;
  end

  // Read mux over pre-write register values
  always_comb begin
    w_rdata_n = '0;
    case (w_addr)
      ADDR_UART_STATUS: w_rdata_n = w_status;
      ADDR_LED:         w_rdata_n = {8'h00, r_leds};
      ADDR_TIMER:       w_rdata_n = r_timer;
`ifdef RCPU_IO_RX_EN
      ADDR_RX:          w_rdata_n = {8'h00, r_rx_data};
`endif
      default:          w_rdata_n = '0;
    endcase
  end

  // Read data register, held between read strobes
  always_ff @(posedge clk) begin
    if (reset)     r_rdata <= '0;
    else if (w_rd) r_rdata <= w_rdata_n;
  end

endmodule
